hazard_ctrl: RTL



---
 rtl/hazard_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller for the 5-stage MIPS core.
// Ports: ID/EX register fields and branch result in; PC/IF-ID/ID-EX enables,
//        flush and bubble, and multiply/divide start/busy out.
// Optional macro HAZARD_STATS_EN adds saturating stall_cnt/flush_cnt outputs.
module hazard_ctrl #(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic       ID_usesRt,
  input  logic       ID_mdOp,
  input  logic       ID_usesHiLo,
  input  logic [4:0] IDEX_rt,
  input  logic       IDEX_memRead,
  input  logic       EX_branchTaken,
  output logic       PC_write,
  output logic       IFID_write,
  output logic       IFID_flush,
  output logic       IDEX_bubble,
  output logic       MD_start,
`ifdef HAZARD_STATS_EN
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
`endif
  output logic       MD_busy
);

  typedef enum logic {RUN = 1'b0, MD_BUSY = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic             load_use;
  logic             md_hazard;
  logic             stall;

  // r0 is never a real destination, so a load into it cannot create a hazard.
  assign load_use  = IDEX_memRead && (IDEX_rt != 5'd0) &&
                     ((IDEX_rt == ID_rs) || (ID_usesRt && (IDEX_rt == ID_rt)));
  assign md_hazard = (state_q == MD_BUSY) && (ID_usesHiLo || ID_mdOp);
  assign stall     = load_use || md_hazard;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  // Next-state logic; the busy counter is unaffected by branches.
  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    case (state_q)
      RUN: begin
        if (MD_start) begin
          state_d  = MD_BUSY;
          md_cnt_d = CNT_W'(MD_LAT - 1);
        end
      end
      MD_BUSY: begin
        if (md_cnt_q <= CNT_W'(1)) begin
          state_d  = RUN;
          md_cnt_d = '0;
        end else begin
          md_cnt_d = md_cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d  = RUN;
        md_cnt_d = '0;
      end
    endcase
  end

  // Output logic: reset forcing, then branch squash, then stall, then flow.
  always_comb begin
    PC_write    = 1'b1;
    IFID_write  = 1'b1;
    IFID_flush  = 1'b0;
    IDEX_bubble = 1'b0;
    MD_start    = 1'b0;
    if (!rst_n) begin
      PC_write    = 1'b0;
      IFID_write  = 1'b0;
      IFID_flush  = 1'b1;
      IDEX_bubble = 1'b1;
    end else if (EX_branchTaken) begin
      // The ID instruction is on the wrong path; any MD op there is killed.
      IFID_flush  = 1'b1;
      IDEX_bubble = 1'b1;
    end else if (stall) begin
      PC_write    = 1'b0;
      IFID_write  = 1'b0;
      IDEX_bubble = 1'b1;
    end else begin
      MD_start    = ID_mdOp && (state_q == RUN);
    end
  end

  assign MD_busy = (state_q == MD_BUSY);

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (EX_branchTaken && (flush_cnt_q != 16'hFFFF))
      flush_cnt_d = flush_cnt_q + 16'd1;
    if (!EX_branchTaken && stall && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
